// File: rtl/axi_interconnect_crossbar_sreq_wrr_arbit.sv
// ---------------------------------------------------------------------------
// axi_interconnect_crossbar_sreq_wrr_arbit
// Arbitrates NUM_SLAVE slave AW/AR requests onto one registered master address
// channel. The policy is round-robin, fixed priority or weighted round-robin.
// In write mode an order FIFO of granted port IDs steers W beats from the
// port that owns the oldest outstanding address.
//
// Ports
//   clk_sys, rst          clock, synchronous active-high reset
//   s_addr_info/valid     per-port address payload and request
//   s_addr_ready          one-hot accept (combinational)
//   s_weight              per-port weight (weighted round-robin only)
//   s_wdata_info/valid    per-port W payload (MSB = last) and valid
//   s_wdata_ready         per-port W ready (combinational)
//   addr_info/valid/ready master address channel, {info, port id}, registered
//   wdata_info/valid/ready master W channel, driven by the head port
//   outstanding_cnt       order FIFO occupancy
// ---------------------------------------------------------------------------
module axi_interconnect_crossbar_sreq_wrr_arbit #(
    parameter int unsigned MODE_READ       = 1,
    parameter int unsigned NUM_SLAVE       = 4,
    parameter int unsigned WIDTH_ADDRINFO  = 64,
    parameter int unsigned WIDTH_DATAINFO  = 48,
    parameter int unsigned NUM_OUTSTANDING = 8,
    parameter int unsigned ARB_MODE        = 0,
    parameter int unsigned WEIGHT_WIDTH    = 4,
    localparam int unsigned WIDTH_SLAVE    = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1,
    localparam int unsigned WIDTH_OST      = $clog2(NUM_OUTSTANDING) + 1
) (
    input  logic                                  clk_sys,
    input  logic                                  rst,
    input  logic [NUM_SLAVE*WIDTH_ADDRINFO-1:0]   s_addr_info,
    input  logic [NUM_SLAVE-1:0]                  s_addr_valid,
    output logic [NUM_SLAVE-1:0]                  s_addr_ready,
    input  logic [NUM_SLAVE*WEIGHT_WIDTH-1:0]     s_weight,
    input  logic [NUM_SLAVE*WIDTH_DATAINFO-1:0]   s_wdata_info,
    input  logic [NUM_SLAVE-1:0]                  s_wdata_valid,
    output logic [NUM_SLAVE-1:0]                  s_wdata_ready,
    output logic [WIDTH_ADDRINFO+WIDTH_SLAVE-1:0] addr_info,
    output logic                                  addr_valid,
    input  logic                                  addr_ready,
    output logic [WIDTH_DATAINFO-1:0]             wdata_info,
    output logic                                  wdata_valid,
    input  logic                                  wdata_ready,
    output logic [WIDTH_OST-1:0]                  outstanding_cnt
);

    logic [WIDTH_SLAVE-1:0]                r_last_grant;
    logic [WEIGHT_WIDTH-1:0]               r_credit;
    logic                                  r_addr_valid;
    logic [WIDTH_ADDRINFO+WIDTH_SLAVE-1:0] r_addr_info;

    logic [WIDTH_SLAVE-1:0] w_rr_pick;
    logic [WIDTH_SLAVE-1:0] w_fix_pick;
    logic [WIDTH_SLAVE-1:0] w_grant;
    logic                   w_rr_found;
    logic                   w_hold;
    logic                   w_le;
    logic                   w_fifo_full;
    logic                   w_unused;

    // Some inputs are only consumed for particular MODE_READ / ARB_MODE values.
    assign w_unused = ^{s_weight, s_wdata_info, s_wdata_valid, wdata_ready};

    // Round-robin search starting one past the last granted port.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        for (int i = 1; i <= int'(NUM_SLAVE); i++) begin
            if (!w_rr_found && s_addr_valid[(int'(r_last_grant) + i) % int'(NUM_SLAVE)]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = WIDTH_SLAVE'((int'(r_last_grant) + i) % int'(NUM_SLAVE));
            end
        end
    end

    // Fixed priority: lowest index requester wins.
    always_comb begin
        w_fix_pick = '0;
        for (int i = int'(NUM_SLAVE) - 1; i >= 0; i--) begin
            if (s_addr_valid[i]) begin
                w_fix_pick = WIDTH_SLAVE'(i);
            end
        end
    end

    // Weighted RR keeps the current owner while it requests and has credit left.
    assign w_hold  = (ARB_MODE == 2) && s_addr_valid[r_last_grant] && (r_credit != '0);
    assign w_grant = (ARB_MODE == 1) ? w_fix_pick : (w_hold ? r_last_grant : w_rr_pick);

    assign w_le = !rst && (!r_addr_valid || addr_ready) && (|s_addr_valid) &&
                  ((MODE_READ != 0) || !w_fifo_full);

    assign s_addr_ready = w_le ? (NUM_SLAVE'(1) << w_grant) : '0;
    assign addr_info    = r_addr_info;
    assign addr_valid   = r_addr_valid;

    // Registered address stage: load on accept, hold under backpressure.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_addr_valid <= 1'b0;
            r_addr_info  <= '0;
        end else if (w_le) begin
            r_addr_valid <= 1'b1;
            r_addr_info  <= {s_addr_info[w_grant*WIDTH_ADDRINFO +: WIDTH_ADDRINFO], w_grant};
        end else if (addr_ready) begin
            r_addr_valid <= 1'b0;
        end
    end

    // Arbiter history and weighted-RR credit.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_last_grant <= WIDTH_SLAVE'(NUM_SLAVE - 1);
            r_credit     <= '0;
        end else begin
            if (w_le) begin
                r_last_grant <= w_grant;
            end
            if (ARB_MODE == 2) begin
                if (w_le) begin
                    r_credit <= w_hold ? (r_credit - WEIGHT_WIDTH'(1))
                                       : s_weight[w_grant*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                end else if (!s_addr_valid[r_last_grant]) begin
                    // Owner dropped its request: forfeit remaining credit.
                    r_credit <= '0;
                end
            end
        end
    end

    if (MODE_READ == 0) begin : g_write
        logic [WIDTH_SLAVE-1:0] r_fifo [NUM_OUTSTANDING];
        logic [WIDTH_OST-1:0]   r_wptr;
        logic [WIDTH_OST-1:0]   r_rptr;
        logic [WIDTH_SLAVE-1:0] w_head;
        logic                   w_empty;
        logic                   w_pop;

        // Pointers carry one extra MSB so full and empty are distinguishable.
        assign w_empty     = (r_wptr == r_rptr);
        assign w_fifo_full = (r_wptr[WIDTH_OST-1] != r_rptr[WIDTH_OST-1]) &&
                             (r_wptr[WIDTH_OST-2:0] == r_rptr[WIDTH_OST-2:0]);
        assign w_head      = r_fifo[r_rptr[WIDTH_OST-2:0]];

        assign wdata_info      = s_wdata_info[w_head*WIDTH_DATAINFO +: WIDTH_DATAINFO];
        assign wdata_valid     = !w_empty && s_wdata_valid[w_head];
        assign s_wdata_ready   = (!w_empty && wdata_ready) ? (NUM_SLAVE'(1) << w_head) : '0;
        assign w_pop           = wdata_valid && wdata_ready && wdata_info[WIDTH_DATAINFO-1];
        assign outstanding_cnt = r_wptr - r_rptr;

        // Order FIFO: push each granted port ID, pop on the last W beat.
        always_ff @(posedge clk_sys) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_le) begin
                    r_fifo[r_wptr[WIDTH_OST-2:0]] <= w_grant;
                    r_wptr                         <= r_wptr + WIDTH_OST'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + WIDTH_OST'(1);
                end
            end
        end
    end else begin : g_read
        assign w_fifo_full     = 1'b0;
        assign wdata_info      = '0;
        assign wdata_valid     = 1'b0;
        assign s_wdata_ready   = '0;
        assign outstanding_cnt = '0;
    end

endmodule
